// File: rtl/pl_stage_fifo.sv
// pl_stage_fifo: a pipeline-stage buffer that holds DEPTH entries and uses a
// valid/ready handshake on each side.
// Each entry has a control field and a data field. The control field reads
// as zero whenever no valid entry is presented, so an empty stage looks like
// a bubble downstream. Flush zeroes the stored control fields and leaves the
// data fields as they are.
// The output is always registered: nothing passes combinationally from in_*
// to out_*. With PASS_READY = 1, in_ready also rises when the stage is full
// and out_ready is high, which gives full throughput at DEPTH = 1.
module pl_stage_fifo #(
  parameter  int CTRL_W     = 8,
  parameter  int DATA_W     = 128,
  parameter  int DEPTH      = 2,
  parameter  int PASS_READY = 0,
  parameter  int CNT_W      = 16,
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  // A single-entry stage still gets a 1-bit pointer. That pointer only ever
  // holds 0.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // DEPTH need not be a power of two, so the pointer wraps explicitly.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode, output view of the head entry, and occupancy.
  always_comb begin
    full      = (count == OCC_FULL);
    empty     = (count == '0);
    if (PASS_READY != 0) in_ready = !full || out_ready;
    else                 in_ready = !full;
    out_valid = !empty;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = data_mem[rd_ptr];
    out_ctrl  = out_valid ? ctrl_mem[rd_ptr] : '0;
    occupancy = count;
  end

  // Control storage. Flush zeroes every entry, and a push in the same cycle
  // as a flush is dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) ctrl_mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ctrl_mem[i] <= '0;
    end else if (push) begin
      ctrl_mem[wr_ptr] <= in_ctrl;
    end
  end

  // Data storage. Only reset clears it; flush does not touch stored data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) data_mem[i] <= '0;
    end else if (push && !flush) begin
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and count. Flush empties the stage by moving rd_ptr up to wr_ptr.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating count of cycles in which the downstream holds off a valid
  // head. It keeps counting through a flush cycle and is not cleared by it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pl_stage_fifo.sv
// Bench for pl_stage_fifo. Two instances share one stimulus stream:
//   inst 0: DEPTH=2, PASS_READY=0, CNT_W=16
//   inst 1: DEPTH=3, PASS_READY=1, CNT_W=4
// Each instance has its own reference model. The model is an ordered list of
// entries with the head at index 0, plus a saturating stall count.
module tb_pl_stage_fifo;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         flush;
  logic         in_valid;
  logic [7:0]   in_ctrl;
  logic [127:0] in_data;
  logic         out_ready;

  logic         a_in_ready, a_out_valid;
  logic [7:0]   a_out_ctrl;
  logic [127:0] a_out_data;
  logic [1:0]   a_occ;
  logic [15:0]  a_stall;

  logic         b_in_ready, b_out_valid;
  logic [7:0]   b_out_ctrl;
  logic [127:0] b_out_data;
  logic [1:0]   b_occ;
  logic [3:0]   b_stall;

  int total = 0;
  int bad   = 0;

  int           depth [2] = '{2, 3};
  int           pr    [2] = '{0, 1};
  int           cmax  [2] = '{65535, 15};
  int           m_cnt [2];
  int           m_stall [2];
  logic [7:0]   m_ctrl [2][8];
  logic [127:0] m_data [2][8];
  logic [127:0] saved_head;

  always #5 CLK = ~CLK;

  pl_stage_fifo #(.CTRL_W(8), .DATA_W(128), .DEPTH(2), .PASS_READY(0), .CNT_W(16)) u_a (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cycles(a_stall));

  pl_stage_fifo #(.CTRL_W(8), .DATA_W(128), .DEPTH(3), .PASS_READY(1), .CNT_W(4)) u_b (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .stall_cycles(b_stall));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic v, input logic [7:0] c,
                            input logic [127:0] d, input logic [1:0] occ,
                            input logic r, input logic [15:0] st);
    logic exp_v;
    logic exp_r;
    exp_v = (m_cnt[i] != 0);
    exp_r = (m_cnt[i] != depth[i]) || ((pr[i] != 0) && out_ready);
    chk($sformatf("out_valid[%0d]", i), v, exp_v);
    chk($sformatf("out_ctrl[%0d]", i), c, exp_v ? m_ctrl[i][0] : 8'h00);
    if (exp_v) chk($sformatf("out_data[%0d]", i), d, m_data[i][0]);
    chk($sformatf("occupancy[%0d]", i), occ, m_cnt[i]);
    chk($sformatf("in_ready[%0d]", i), r, exp_r);
    chk($sformatf("stall[%0d]", i), st, m_stall[i]);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid_a", a_out_valid, 0);   chk("rst_valid_b", b_out_valid, 0);
    chk("rst_ctrl_a", a_out_ctrl, 0);     chk("rst_ctrl_b", b_out_ctrl, 0);
    chk("rst_data_a", a_out_data, 0);     chk("rst_data_b", b_out_data, 0);
    chk("rst_occ_a", a_occ, 0);           chk("rst_occ_b", b_occ, 0);
    chk("rst_ready_a", a_in_ready, 1);    chk("rst_ready_b", b_in_ready, 1);
    chk("rst_stall_a", a_stall, 0);       chk("rst_stall_b", b_stall, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]   = 0;
      m_stall[i] = 0;
    end
  endtask

  // One clock edge of the model, using the input values that are stable
  // across that edge.
  task automatic model_update(input int i);
    logic rdy, vld, psh, pp;
    rdy = (m_cnt[i] != depth[i]) || ((pr[i] != 0) && out_ready);
    vld = (m_cnt[i] != 0);
    psh = in_valid && rdy;
    pp  = vld && out_ready;
    if (vld && !out_ready && m_stall[i] < cmax[i]) m_stall[i]++;
    if (flush) begin
      m_cnt[i] = 0;
    end else begin
      if (pp) begin
        for (int k = 0; k < 7; k++) begin
          m_ctrl[i][k] = m_ctrl[i][k+1];
          m_data[i][k] = m_data[i][k+1];
        end
        m_cnt[i]--;
      end
      if (psh) begin
        m_ctrl[i][m_cnt[i]] = in_ctrl;
        m_data[i][m_cnt[i]] = in_data;
        m_cnt[i]++;
      end
    end
  endtask

  task automatic step();
    #1;
    check_inst(0, a_out_valid, a_out_ctrl, a_out_data, a_occ, a_in_ready, a_stall);
    check_inst(1, b_out_valid, b_out_ctrl, b_out_data, b_occ, b_in_ready, 16'(b_stall));
    @(posedge CLK);
    model_update(0);
    model_update(1);
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [127:0] d,
                       input logic r, input logic f);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = f;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    nRST = 1'b0;
    drive(0, 8'h00, '0, 0, 0);
    model_reset();
    @(negedge CLK);
    #1;
    check_reset_outputs();
    nRST = 1'b1;
    step();
    step();

    // Two pushes while the downstream stalls, then drain in order.
    drive(1, 8'h81, 128'hA, 0, 0); step();
    drive(1, 8'h82, 128'hB, 0, 0); step();
    drive(0, 8'h00, '0, 0, 0);     step();
    #1;
    chk("two_push_occ_a", a_occ, 2);
    chk("two_push_rdy_a", a_in_ready, 0);
    chk("two_push_ctrl_a", a_out_ctrl, 8'h81);
    chk("two_push_stall_a", a_stall, 2);
    drive(0, 8'h00, '0, 1, 0);
    for (int k = 0; k < 4; k++) step();

    // Continuous stream of ten entries.
    for (int k = 0; k < 10; k++) begin
      drive(1, 8'($urandom), 128'(k), 1, 0);
      step();
    end
    drive(0, 8'h00, '0, 1, 0);
    for (int k = 0; k < 3; k++) step();

    // Fill both instances, then push and pop together while full.
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'($urandom), rnd128(), 0, 0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'($urandom), rnd128(), 1, 0);
      #1;
      chk("pass_ready_b", b_in_ready, 1);
      step();
    end

    // Flush while instance 0 is full, with a push and a pop in the same cycle.
    drive(0, 8'h00, '0, 1, 0);
    for (int k = 0; k < 4; k++) step();
    drive(1, 8'h11, 128'h111, 0, 0); step();
    drive(1, 8'h22, 128'h222, 0, 0); step();
    saved_head = m_data[0][0];
    drive(1, 8'h33, 128'h333, 1, 1); step();
    drive(0, 8'h00, '0, 0, 0);
    #1;
    chk("flush_occ_a", a_occ, 0);
    chk("flush_valid_a", a_out_valid, 0);
    chk("flush_ctrl_a", a_out_ctrl, 0);
    chk("flush_data_a", a_out_data, saved_head);
    step();
    step();

    // Stall for twenty cycles. The 4-bit counter saturates.
    drive(1, 8'h44, 128'h444, 0, 0); step();
    drive(0, 8'h00, '0, 0, 0);
    for (int k = 0; k < 20; k++) step();
    #1;
    chk("stall_sat_b", b_stall, 4'hF);

    // Random traffic with occasional flushes.
    drive(0, 8'h00, '0, 1, 0);
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), rnd128(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      step();
    end

    // Asynchronous reset in the middle of traffic.
    drive(1, 8'h55, 128'h555, 0, 0); step();
    drive(1, 8'h66, 128'h666, 0, 0); step();
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    drive(0, 8'h00, '0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive($urandom_range(0, 1) != 0, 8'($urandom), rnd128(),
            $urandom_range(0, 1) != 0, 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
